// File: rtl/dca_tensor_vector_adder_if.sv
// dca_tensor_vector_adder_if: operand/result bundle between tensor fetch, the lane adder and writeback
interface dca_tensor_vector_adder_if #(
   parameter int NUM_LANE = 4,
   parameter int BW_DATA  = 16
);
   logic                         enable;
   logic                         in_valid;
   logic [1:0]                   in_mode;
   logic                         in_last;
   logic [NUM_LANE*BW_DATA-1:0]  in_input0;
   logic [NUM_LANE*BW_DATA-1:0]  in_input1;
   logic                         out_valid;
   logic                         out_last;
   logic [NUM_LANE*BW_DATA-1:0]  out_result;
   logic [NUM_LANE-1:0]          out_overflow;
   modport master (
      output enable, in_valid, in_mode, in_last, in_input0, in_input1,
      input  out_valid, out_last, out_result, out_overflow
   );
   modport slave (
      input  enable, in_valid, in_mode, in_last, in_input0, in_input1,
      output out_valid, out_last, out_result, out_overflow
   );
endinterface

// File: rtl/dca_tensor_vector_adder.sv
// dca_tensor_vector_adder: multi-lane signed add/sub with burst accumulate, optional saturation, fixed-depth pipeline
module dca_tensor_vector_adder #(
   parameter int NUM_LANE   = 4,
   parameter int BW_DATA    = 16,
   parameter int PIPE_DEPTH = 2,
   parameter int SATURATE   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   dca_tensor_vector_adder_if.slave bus
);
   localparam int W  = BW_DATA + 2;
   localparam int LW = NUM_LANE * BW_DATA;

   if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
      $error("dca_tensor_vector_adder: PIPE_DEPTH must lie in 1..4");
   end

   typedef enum logic {S_IDLE, S_ACCUM} state_t;

   state_t               r_state;
   logic [LW-1:0]        r_acc;
   logic [NUM_LANE-1:0]  r_sticky;
   logic                 r_vld [PIPE_DEPTH];
   logic                 r_lst [PIPE_DEPTH];
   logic [LW-1:0]        r_res [PIPE_DEPTH];
   logic [NUM_LANE-1:0]  r_ovf [PIPE_DEPTH];

   logic                 w_accept;
   logic                 w_acc_mode;
   logic                 w_sub;
   logic                 w_use_acc;
   logic [LW-1:0]        w_clip;
   logic [NUM_LANE-1:0]  w_ovf;
   logic [NUM_LANE-1:0]  w_flag;

   assign w_accept   = bus.enable & bus.in_valid;
   assign w_acc_mode = bus.in_mode[1];
   assign w_sub      = bus.in_mode[0];
   // acc only contributes while a burst is open; IDLE behaves as a zero accumulator
   assign w_use_acc  = w_acc_mode && r_state == S_ACCUM;
   assign w_flag     = w_ovf | (w_use_acc ? r_sticky : '0);

   for (genvar i = 0; i < NUM_LANE; i++) begin : g_lane
      logic [BW_DATA-1:0] w_ai, w_bi, w_ci;
      logic [W-1:0]       w_b, w_sum;
      assign w_ai = bus.in_input0[i*BW_DATA +: BW_DATA];
      assign w_bi = bus.in_input1[i*BW_DATA +: BW_DATA];
      assign w_ci = r_acc[i*BW_DATA +: BW_DATA];
      // subtraction as A + ~B + 1 at the widened width so the carry-in closes the two's complement
      assign w_b   = {{2{w_bi[BW_DATA-1]}}, w_bi} ^ {W{w_sub}};
      assign w_sum = (w_use_acc ? {{2{w_ci[BW_DATA-1]}}, w_ci} : {W{1'b0}})
                   + {{2{w_ai[BW_DATA-1]}}, w_ai} + w_b + W'(w_sub);
      // out of range exactly when the bits above the result sign disagree with it
      assign w_ovf[i] = w_sum[W-1:BW_DATA-1] != {3{w_sum[W-1]}};
      assign w_clip[i*BW_DATA +: BW_DATA] = (w_ovf[i] && SATURATE != 0)
         ? (w_sum[W-1] ? {1'b1, {(BW_DATA-1){1'b0}}} : {1'b0, {(BW_DATA-1){1'b1}}})
         : w_sum[BW_DATA-1:0];
   end

   // burst accumulator FSM: opens on a non-last ACC beat, closes and clears on a last ACC beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_acc    <= '0;
         r_sticky <= '0;
      end else if (w_accept && w_acc_mode) begin
         r_state  <= bus.in_last ? S_IDLE : S_ACCUM;
         r_acc    <= bus.in_last ? '0 : w_clip;
         r_sticky <= bus.in_last ? '0 : w_flag;
      end
   end

   // stage 1 captures the lane results; later stages are a plain delay line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            r_vld[k] <= 1'b0;
            r_lst[k] <= 1'b0;
            r_res[k] <= '0;
            r_ovf[k] <= '0;
         end
      end else if (bus.enable) begin
         r_vld[0] <= bus.in_valid && (!w_acc_mode || bus.in_last);
         r_lst[0] <= bus.in_valid && w_acc_mode && bus.in_last;
         r_res[0] <= w_clip;
         r_ovf[0] <= w_flag;
         for (int k = 1; k < PIPE_DEPTH; k++) begin
            r_vld[k] <= r_vld[k-1];
            r_lst[k] <= r_lst[k-1];
            r_res[k] <= r_res[k-1];
            r_ovf[k] <= r_ovf[k-1];
         end
      end
   end

   assign bus.out_valid    = r_vld[PIPE_DEPTH-1];
   assign bus.out_last     = r_lst[PIPE_DEPTH-1];
   assign bus.out_result   = r_res[PIPE_DEPTH-1];
   assign bus.out_overflow = r_ovf[PIPE_DEPTH-1];
endmodule
